// File: rtl/alu_sequencer.sv
// Sequencer that owns a 4x8 register file and drives an external registered ALU.
// Each instruction takes three cycles: issue, wait for the ALU, write back.
module alu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [DATA_W-1:0] done_data,
    output logic              zero,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] regfile_q [4];
    logic [DATA_W-1:0] regfile_d [4];
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [1:0]        opcode_q,    opcode_d;
    logic [1:0]        dst_q,       dst_d;
    logic              done_q,      done_d;
    logic [DATA_W-1:0] done_data_q, done_data_d;
    logic              zero_q,      zero_d;

    logic [1:0] instrOp;
    logic [1:0] instrDst;
    logic [1:0] instrSrcA;
    logic [1:0] instrSrcB;

    assign instrOp   = instr[7:6];
    assign instrDst  = instr[5:4];
    assign instrSrcA = instr[3:2];
    assign instrSrcB = instr[1:0];

    // A load in the same cycle wins; the instruction simply waits for the next IDLE cycle.
    assign ld_ready    = (state_q == IDLE);
    assign instr_ready = (state_q == IDLE) && !ld_valid;

    always_comb begin
        state_d     = state_q;
        regfile_d   = regfile_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        opcode_d    = opcode_q;
        dst_d       = dst_q;
        done_d      = 1'b0;
        done_data_d = done_data_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    regfile_d[ld_addr] = ld_data;
                end else if (instr_valid) begin
                    alu_a_d  = regfile_q[instrSrcA];
                    alu_b_d  = regfile_q[instrSrcB];
                    opcode_d = instrOp;
                    dst_d    = instrDst;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                // The ALU output is registered, so it is valid only now, one cycle after EXEC.
                regfile_d[dst_q] = alu_result;
                done_data_d      = alu_result;
                zero_d           = (alu_result == '0);
                done_d           = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < 4; i++) begin
                regfile_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            opcode_q    <= 2'b00;
            dst_q       <= 2'b00;
            done_q      <= 1'b0;
            done_data_q <= '0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 4; i++) begin
                regfile_q[i] <= regfile_d[i];
            end
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            opcode_q    <= opcode_d;
            dst_q       <= dst_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
            zero_q      <= zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = opcode_q;
    assign done       = done_q;
    assign done_data  = done_data_q;
    assign zero       = zero_q;
    assign rd_data    = regfile_q[rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered ALU model attached.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] instr = '0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [1:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_opcode;
    logic [7:0] alu_result = '0;
    logic       done;
    logic [7:0] done_data;
    logic       zero;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;

    int assertCount = 0;
    int failCount   = 0;

    alu_sequencer #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .done        (done),
        .done_data   (done_data),
        .zero        (zero),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    // External ALU: result registered one clock after the operands.
    always @(posedge clk) begin
        case (alu_opcode)
            2'b00:   alu_result <= alu_a + alu_b;
            2'b01:   alu_result <= alu_a - alu_b;
            2'b10:   alu_result <= alu_a & alu_b;
            default: alu_result <= alu_a | alu_b;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives all inputs at the falling edge, then settles so checks see stable values.
    task automatic applyStimulus(input logic ldV, input logic [1:0] ldA, input logic [7:0] ldD,
                                 input logic iV, input logic [7:0] ins, input logic [1:0] rdA);
        @(negedge clk);
        ld_valid    = ldV;
        ld_addr     = ldA;
        ld_data     = ldD;
        instr_valid = iV;
        instr       = ins;
        rd_addr     = rdA;
        #1;
    endtask

    task automatic runInstr(input string tag, input logic [7:0] ins, input logic [7:0] expA,
                            input logic [7:0] expB, input logic [7:0] expRes);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, ins, 2'd0);
        checkOutput({tag, "_ready"}, instr_ready, 1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, ins[5:4]);
        checkOutput({tag, "_exec_ready"}, instr_ready, 0);
        checkOutput({tag, "_alu_a"}, alu_a, expA);
        checkOutput({tag, "_alu_b"}, alu_b, expB);
        checkOutput({tag, "_opcode"}, alu_opcode, ins[7:6]);
        checkOutput({tag, "_exec_done"}, done, 0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, ins[5:4]);
        checkOutput({tag, "_wb_done"}, done, 0);
        checkOutput({tag, "_wb_alu_a"}, alu_a, expA);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, ins[5:4]);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_done_data"}, done_data, expRes);
        checkOutput({tag, "_zero"}, zero, (expRes == 8'h00));
        checkOutput({tag, "_rd_dst"}, rd_data, expRes);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, ins[5:4]);
        checkOutput({tag, "_done_low"}, done, 0);
        checkOutput({tag, "_done_data_hold"}, done_data, expRes);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_opcode", alu_opcode, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_done_data", done_data, 0);
        checkOutput("rst_zero", zero, 1);
        checkOutput("rst_rd", rd_data, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ld_ready", ld_ready, 1);
        checkOutput("post_rst_instr_ready", instr_ready, 1);

        // Subtraction r2 = r0 - r1
        applyStimulus(1'b1, 2'd0, 8'h05, 1'b0, 8'h00, 2'd0);
        checkOutput("ld_ready", ld_ready, 1);
        checkOutput("ld_blocks_instr", instr_ready, 0);
        applyStimulus(1'b1, 2'd1, 8'h07, 1'b0, 8'h00, 2'd0);
        checkOutput("ld_r0", rd_data, 8'h05);
        runInstr("sub", 8'b01_10_00_01, 8'h05, 8'h07, 8'hFE);

        // Wrap-around addition r3 = r0 + r1
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0, 8'h00, 2'd0);
        applyStimulus(1'b1, 2'd1, 8'h01, 1'b0, 8'h00, 2'd0);
        runInstr("add_wrap", 8'b00_11_00_01, 8'hFF, 8'h01, 8'h00);

        // Load and instruction together: load first, instruction next cycle sees the new r2
        applyStimulus(1'b1, 2'd2, 8'h11, 1'b1, 8'b11_01_10_01, 2'd2);
        checkOutput("prio_instr_ready", instr_ready, 0);
        checkOutput("prio_ld_ready", ld_ready, 1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 8'b11_01_10_01, 2'd2);
        checkOutput("prio_r2_loaded", rd_data, 8'h11);
        checkOutput("prio_instr_next", instr_ready, 1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
        checkOutput("prio_alu_a", alu_a, 8'h11);
        checkOutput("prio_alu_b", alu_b, 8'h01);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
        checkOutput("prio_done", done, 1);
        checkOutput("prio_done_data", done_data, 8'h11);
        checkOutput("prio_rd_r1", rd_data, 8'h11);

        // Back-to-back aliased "or r0 = r0 | r0" held valid
        applyStimulus(1'b1, 2'd0, 8'h3C, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, (k < 9), 8'b11_00_00_00, 2'd0);
            checkOutput($sformatf("b2b_ready_%0d", k), instr_ready, (k % 3 == 0));
            checkOutput($sformatf("b2b_done_%0d", k), done, (k >= 3 && k % 3 == 0));
            if (k >= 3) begin
                checkOutput($sformatf("b2b_data_%0d", k), done_data, 8'h3C);
            end
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd0);
        checkOutput("b2b_done_end", done, 0);
        checkOutput("b2b_r0", rd_data, 8'h3C);

        // Load attempt during EXEC of "and r1 = r0 & r1" must be ignored
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 8'b10_01_00_01, 2'd2);
        applyStimulus(1'b1, 2'd2, 8'hAA, 1'b0, 8'h00, 2'd2);
        checkOutput("exec_ld_ready", ld_ready, 0);
        applyStimulus(1'b1, 2'd2, 8'hAA, 1'b0, 8'h00, 2'd2);
        checkOutput("wb_ld_ready", ld_ready, 0);
        checkOutput("exec_ld_r2", rd_data, 8'h11);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd2);
        checkOutput("and_done", done, 1);
        checkOutput("and_done_data", done_data, 8'h10);
        checkOutput("ld_ignored_r2", rd_data, 8'h11);

        // Reset during EXEC aborts the instruction
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 8'b10_01_00_01, 2'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
        checkOutput("abort_exec_alu_a", alu_a, 8'h3C);
        rst = 1'b1;
        #1;
        checkOutput("abort_alu_a", alu_a, 0);
        checkOutput("abort_alu_b", alu_b, 0);
        checkOutput("abort_opcode", alu_opcode, 0);
        checkOutput("abort_done_data", done_data, 0);
        checkOutput("abort_zero", zero, 1);
        checkOutput("abort_r1", rd_data, 0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd1);
            checkOutput($sformatf("abort_no_done_%0d", k), done, 0);
            checkOutput($sformatf("abort_r1_%0d", k), rd_data, 0);
            checkOutput($sformatf("abort_idle_%0d", k), instr_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, the operand/result width; SHALL match the ALU datapath (only 8 supported).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  instruction accepted when valid&&ready at a rising edge.
REQ-006 instr  in  8  [7:6] op, [5:4] dst, [3:2] srcA, [1:0] srcB.
REQ-007 ld_valid  in  1  register-load request.
REQ-008 ld_ready  out  1  load accepted when ld_valid&&ld_ready at a rising edge.
REQ-009 ld_addr  in  2  register written by a load.
REQ-010 ld_data  in  8  value written by a load.
REQ-011 alu_a  out  8  ALU operand A.
REQ-012 alu_b  out  8  ALU operand B.
REQ-013 alu_opcode  out  2  ALU op (00 add, 01 sub, 10 and, 11 or).
REQ-014 alu_result  in  8  registered ALU result, valid one clock after operands are presented.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 done_data  out  8  result of the last completed instruction.
REQ-017 zero  out  1  done_data == 0.
REQ-018 rd_addr  in  2  debug read address.
REQ-019 rd_data  out  8  combinational read of regfile[rd_addr].

Function
REQ-020 The block SHALL contain a 4x8 register file and FSM states IDLE, EXEC, WB.
REQ-021 ld_ready SHALL be 1 only in IDLE; instr_ready SHALL be 1 only in IDLE with ld_valid=0 (load has priority over an instruction in the same cycle).
REQ-022 An accepted load SHALL write regfile[ld_addr]=ld_data at that edge; state stays IDLE; done not asserted.
REQ-023 An accepted instruction SHALL, at the same edge, register alu_a=regfile[srcA], alu_b=regfile[srcB], alu_opcode=op, latch dst, and go IDLE->EXEC.
REQ-024 EXEC SHALL last exactly one cycle, then go to WB, with alu_a/alu_b/alu_opcode held stable.
REQ-025 At the WB->IDLE edge, regfile[dst]=alu_result, done_data=alu_result, zero=(alu_result==0), done=1.
REQ-026 done SHALL be high for exactly the one IDLE cycle after WB and 0 otherwise.
REQ-027 Latency: accept at edge N -> done high in the cycle after edge N+2; peak throughput is one instruction per 3 cycles (a new instruction may be accepted in the done cycle).
REQ-028 srcA, srcB and dst may alias; operands SHALL be the pre-instruction values.
REQ-029 Arithmetic is modulo 2^8 (performed by the ALU); the block SHALL not alter or extend alu_result.
REQ-030 ld_valid/instr_valid while not IDLE SHALL be ignored with no side effects.
REQ-031 alu_a, alu_b, alu_opcode, done_data and zero SHALL retain their values between instructions.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, all regfile entries=0, alu_a=alu_b=0, alu_opcode=00, done=0, done_data=0, zero=1.
REQ-033 Reset asserted in EXEC or WB SHALL abort the instruction with no writeback and no done pulse.
REQ-034 After rst deasserts, ld_ready=1 and instr_ready=!ld_valid in the first cycle.

Verification
REQ-035 Load r0=8'h05, r1=8'h07; instr sub r2=r0-r1 (8'b01_10_00_01) -> done 3 cycles after accept, done_data=8'hFE, zero=0, rd_data(r2)=8'hFE.
REQ-036 r0=8'hFF, r1=8'h01, add r3=r0+r1 -> done_data=8'h00, zero=1 (wrap-around).
REQ-037 ld_valid and instr_valid both high in IDLE -> load taken, instr_ready=0 that cycle, instruction taken next cycle.
REQ-038 Back-to-back instructions held valid -> accepts every 3rd cycle; each done pulse exactly 1 cycle wide; aliasing "or r0=r0|r0" with r0=8'h3C -> 8'h3C.
REQ-039 rst pulsed during EXEC of "and r1=r0&r1" -> no done, r1 reads 0, all outputs at reset values.
REQ-040 ld_valid asserted during EXEC -> ld_ready=0, regfile unchanged.
